// File: rtl/aes_block_scheduler_if.sv
// ============================================================================
// Module      : aes_block_scheduler_if
// Description : Packet-FIFO read port and AES block handshake bundle.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface aes_block_scheduler_if #(
  parameter int NUMBITS    = 8,
  parameter int BLOCKBYTES = 16,
  parameter int CNTBITS    = 5
);
  logic                          fifo_empty;
  logic [NUMBITS-1:0]            fifo_r_data;
  logic                          fifo_r_enable;
  logic                          eop;
  logic [NUMBITS*BLOCKBYTES-1:0] blk_data;
  logic [CNTBITS-1:0]            blk_bytes;
  logic                          blk_valid;
  logic                          blk_ready;
  logic                          pkt_done;
  logic                          busy;

  // Scheduler side
  modport master (
    input  fifo_empty,
    input  fifo_r_data,
    output fifo_r_enable,
    input  eop,
    output blk_data,
    output blk_bytes,
    output blk_valid,
    input  blk_ready,
    output pkt_done,
    output busy
  );

  // FIFO / AES-core side
  modport slave (
    output fifo_empty,
    output fifo_r_data,
    input  fifo_r_enable,
    output eop,
    input  blk_data,
    input  blk_bytes,
    input  blk_valid,
    output blk_ready,
    input  pkt_done,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/aes_block_scheduler.sv
// ============================================================================
// Module      : aes_block_scheduler
// Description : Drains the show-ahead packet FIFO into padded AES blocks.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_block_scheduler #(
  parameter int                 NUMBITS    = 8,
  parameter int                 BLOCKBYTES = 16,
  parameter int                 CNTBITS    = 5,
  parameter logic [NUMBITS-1:0] PAD_BYTE   = '0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  aes_block_scheduler_if.master bus
);

  localparam logic [CNTBITS-1:0] c_full = CNTBITS'(BLOCKBYTES);
  localparam logic [CNTBITS-1:0] c_last = CNTBITS'(BLOCKBYTES - 1);
  localparam logic [CNTBITS-1:0] c_zero = '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    PAD     = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_next_state;
  logic [CNTBITS-1:0]            r_count;
  logic                          r_eop_pend;
  logic [NUMBITS*BLOCKBYTES-1:0] r_blk_data;

  logic w_pop;
  logic w_accept;
  logic w_eop_seen;
  logic w_blk_valid;
  logic w_pkt_done;
  logic w_busy;

  // Same-cycle eop counts toward the end-of-packet decision at a handshake
  assign w_eop_seen = r_eop_pend | bus.eop;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_accept     = 1'b0;
    w_blk_valid  = 1'b0;
    w_pkt_done   = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (!bus.fifo_empty || r_eop_pend) begin
          w_next_state = FILL;
        end
      end
      FILL: begin
        w_pop = !bus.fifo_empty && (r_count < c_full);
        if (w_pop && (r_count == c_last)) begin
          w_next_state = PRESENT;
        end else if (r_eop_pend && bus.fifo_empty) begin
          w_next_state = (r_count == c_zero) ? DONE : PAD;
        end
      end
      PAD: begin
        w_next_state = PRESENT;
      end
      PRESENT: begin
        w_blk_valid = 1'b1;
        w_accept    = bus.blk_ready;
        if (bus.blk_ready) begin
          w_next_state = (w_eop_seen && bus.fifo_empty) ? DONE : FILL;
        end
      end
      DONE: begin
        w_pkt_done   = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Block assembly: byte slot k sits at the MSB end for k=0
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count    <= '0;
      r_blk_data <= '0;
    end else begin
      if (w_pop) begin
        for (int k = 0; k < BLOCKBYTES; k++) begin
          if (CNTBITS'(k) == r_count) begin
            r_blk_data[NUMBITS*(BLOCKBYTES-k)-1 -: NUMBITS] <= bus.fifo_r_data;
          end
        end
        r_count <= r_count + CNTBITS'(1);
      end else if (r_state == PAD) begin
        for (int k = 0; k < BLOCKBYTES; k++) begin
          if (CNTBITS'(k) >= r_count) begin
            r_blk_data[NUMBITS*(BLOCKBYTES-k)-1 -: NUMBITS] <= PAD_BYTE;
          end
        end
      end else if (w_accept) begin
        r_count    <= '0;
        r_blk_data <= '0;
      end
    end
  end

  // A second eop before pkt_done is absorbed into the pending flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_eop_pend <= 1'b0;
    end else if (r_state == DONE) begin
      r_eop_pend <= 1'b0;
    end else if (bus.eop) begin
      r_eop_pend <= 1'b1;
    end
  end

  assign bus.fifo_r_enable = w_pop;
  assign bus.blk_data      = r_blk_data;
  assign bus.blk_bytes     = r_count;
  assign bus.blk_valid     = w_blk_valid;
  assign bus.pkt_done      = w_pkt_done;
  assign bus.busy          = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_aes_block_scheduler.sv
// ============================================================================
// Module      : tb_aes_block_scheduler
// Description : Directed bench for aes_block_scheduler with a show-ahead FIFO.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_block_scheduler;

  logic clk;
  logic n_rst;

  aes_block_scheduler_if #(.NUMBITS(8), .BLOCKBYTES(16), .CNTBITS(5)) bus ();

  aes_block_scheduler #(
    .NUMBITS    (8),
    .BLOCKBYTES (16),
    .CNTBITS    (5),
    .PAD_BYTE   (8'h00)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model: head word visible while not empty
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign bus.fifo_empty  = (wr_ptr == rd_ptr);
  assign bus.fifo_r_data = mem[rd_ptr[7:0]];

  always @(posedge clk) begin
    if (bus.fifo_r_enable === 1'b1) rd_ptr <= rd_ptr + 1;
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[7:0]] = start + 8'(i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic wait_valid(input int max, output int cyc, output int en);
    cyc = 0;
    en  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.fifo_r_enable === 1'b1) en++;
    end while (bus.blk_valid !== 1'b1 && cyc < max);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int  cyc;
  int  en;
  int  bad;
  logic seen_done;
  logic seen_valid;

  initial begin
    clk           = 1'b0;
    n_rst         = 1'b0;
    bus.eop       = 1'b0;
    bus.blk_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_valid", bus.blk_valid, 1'b0);
    check("rst_done",  bus.pkt_done, 1'b0);
    check("rst_ren",   bus.fifo_r_enable, 1'b0);
    check("rst_busy",  bus.busy, 1'b0);
    check("rst_bytes", bus.blk_bytes, 5'd0);
    check("rst_data",  bus.blk_data, 128'h0);
    n_rst = 1'b1;
    @(negedge clk);

    // Full block 00..0F, ready high
    push_seq(8'h00, 16);
    wait_valid(40, cyc, en);
    check("t1_valid",   bus.blk_valid, 1'b1);
    check("t1_latency", cyc, 17);
    check("t1_pops",    en, 16);
    check("t1_data",    bus.blk_data, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_bytes",   bus.blk_bytes, 5'd16);
    check("t1_nodone",  bus.pkt_done, 1'b0);
    @(negedge clk);
    check("t1_vpulse",  bus.blk_valid, 1'b0);
    check("t1_nodone2", bus.pkt_done, 1'b0);
    check("t1_busy",    bus.busy, 1'b1);

    // Five bytes then eop -> padded block
    push_seq(8'hA1, 5);
    bus.eop = 1'b1;
    @(negedge clk);
    bus.eop = 1'b0;
    wait_valid(40, cyc, en);
    check("t2_valid",   bus.blk_valid, 1'b1);
    check("t2_latency", cyc, 6);
    check("t2_data",    bus.blk_data, {40'hA1A2A3A4A5, 88'h0});
    check("t2_bytes",   bus.blk_bytes, 5'd5);
    @(negedge clk);
    check("t2_done",    bus.pkt_done, 1'b1);
    check("t2_vlow",    bus.blk_valid, 1'b0);
    @(negedge clk);
    check("t2_dpulse",  bus.pkt_done, 1'b0);
    check("t2_idle",    bus.busy, 1'b0);

    // Backpressure: ready low 10 cycles, one extra byte queued behind the block
    bus.blk_ready = 1'b0;
    push_seq(8'h10, 17);
    wait_valid(40, cyc, en);
    check("t3_valid", bus.blk_valid, 1'b1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.blk_valid !== 1'b1) bad++;
      if (bus.fifo_r_enable !== 1'b0) bad++;
      if (bus.blk_data !== 128'h101112131415161718191A1B1C1D1E1F) bad++;
      if (bus.blk_bytes !== 5'd16) bad++;
    end
    check("t3_hold", bad, 0);
    bus.blk_ready = 1'b1;
    @(negedge clk);
    check("t3_accept", bus.blk_valid, 1'b0);
    check("t3_resume", bus.fifo_r_enable, 1'b1);
    bus.eop = 1'b1;
    @(negedge clk);
    bus.eop = 1'b0;
    wait_valid(40, cyc, en);
    check("t3_pvalid", bus.blk_valid, 1'b1);
    check("t3_pdata",  bus.blk_data, {8'h20, 120'h0});
    check("t3_pbytes", bus.blk_bytes, 5'd1);
    @(negedge clk);
    check("t3_done",   bus.pkt_done, 1'b1);
    @(negedge clk);

    // eop with empty FIFO and nothing buffered
    check("t4_idle", bus.busy, 1'b0);
    bus.eop = 1'b1;
    @(negedge clk);
    bus.eop = 1'b0;
    seen_done  = 1'b0;
    seen_valid = 1'b0;
    cyc = 0;
    while (!seen_done && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus.blk_valid === 1'b1) seen_valid = 1'b1;
      if (bus.pkt_done === 1'b1) seen_done = 1'b1;
    end
    check("t4_done",    seen_done, 1'b1);
    check("t4_novalid", seen_valid, 1'b0);
    @(negedge clk);
    check("t4_dpulse",  bus.pkt_done, 1'b0);

    // 32 bytes then eop -> two full blocks, no pad block
    push_seq(8'h30, 32);
    bus.eop = 1'b1;
    @(negedge clk);
    bus.eop = 1'b0;
    wait_valid(40, cyc, en);
    check("t5_valid1", bus.blk_valid, 1'b1);
    check("t5_data1",  bus.blk_data, 128'h303132333435363738393A3B3C3D3E3F);
    check("t5_bytes1", bus.blk_bytes, 5'd16);
    @(negedge clk);
    check("t5_nodone", bus.pkt_done, 1'b0);
    wait_valid(40, cyc, en);
    check("t5_valid2", bus.blk_valid, 1'b1);
    check("t5_data2",  bus.blk_data, 128'h404142434445464748494A4B4C4D4E4F);
    check("t5_bytes2", bus.blk_bytes, 5'd16);
    @(negedge clk);
    check("t5_done",   bus.pkt_done, 1'b1);
    @(negedge clk);
    check("t5_nopad",  bus.blk_valid, 1'b0);
    check("t5_idle",   bus.busy, 1'b0);

    // Reset after 7 pops
    push_seq(8'h50, 7);
    cyc = 0;
    while (wr_ptr != rd_ptr && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_drained", (wr_ptr == rd_ptr), 1'b1);
    check("t6_count",   bus.blk_bytes, 5'd7);
    n_rst = 1'b0;
    #1;
    check("t6_rvalid", bus.blk_valid, 1'b0);
    check("t6_rbusy",  bus.busy, 1'b0);
    check("t6_rren",   bus.fifo_r_enable, 1'b0);
    check("t6_rbytes", bus.blk_bytes, 5'd0);
    check("t6_rdata",  bus.blk_data, 128'h0);
    @(negedge clk);
    n_rst = 1'b1;
    push_seq(8'h60, 16);
    wait_valid(40, cyc, en);
    check("t6_valid", bus.blk_valid, 1'b1);
    check("t6_data",  bus.blk_data, 128'h606162636465666768696A6B6C6D6E6F);
    check("t6_bytes", bus.blk_bytes, 5'd16);
    @(negedge clk);
    check("t6_accept", bus.blk_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
